// File: rtl/mem_stage_if.sv
// Data-memory handshake bundle between the memory stage (master) and data memory (slave).
// The request side stays stable from req rise until the ack cycle.
interface mem_stage_if #(
    parameter int DW = 32
);
    logic          dmem_req;
    logic          dmem_we;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_ack;
    logic [DW-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: EX/MEM register, data-memory req/ack FSM with timeout,
// branch resolution and the MEM/WB register.
module mem_stage #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ex_wreg,
    input  logic          ex_m2reg,
    input  logic          ex_wmem,
    input  logic [DW-1:0] ex_aluR,
    input  logic [DW-1:0] ex_inB,
    input  logic [4:0]    ex_destR,
    input  logic          ex_branch,
    input  logic [DW-1:0] ex_pc,
    input  logic          ex_zero,
    input  logic [3:0]    EXE_ins_type,
    input  logic [3:0]    EXE_ins_number,
    mem_stage_if.master   dmem,
    output logic          mem_stall,
    output logic          mem_pcsrc,
    output logic [DW-1:0] mem_branch_pc,
    output logic          mem_err,
    output logic          wb_wreg,
    output logic          wb_m2reg,
    output logic [DW-1:0] wb_aluR,
    output logic [DW-1:0] wb_mdata,
    output logic [4:0]    wb_destR,
    output logic [3:0]    MEM_ins_type,
    output logic [3:0]    MEM_ins_number
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          m_wreg_q, m_m2reg_q, m_wmem_q, m_branch_q, m_zero_q;
    logic [DW-1:0] m_aluR_q, m_inB_q, m_pc_q;
    logic [4:0]    m_destR_q;
    logic [3:0]    m_type_q, m_num_q;

    logic          wb_wreg_q, wb_m2reg_q;
    logic [DW-1:0] wb_aluR_q, wb_mdata_q;
    logic [4:0]    wb_destR_q;
    logic          err_q;

    logic in_access, last_cycle, stall, timed_out, load_done;

    // The final allowed ACCESS cycle always completes, with or without an ack.
    always_comb begin
        in_access  = (state_q == ACCESS);
        last_cycle = in_access && (cnt_q == CW'(TIMEOUT - 1));
        stall      = in_access && !dmem.dmem_ack && !last_cycle;
        timed_out  = last_cycle && !dmem.dmem_ack;
        load_done  = in_access && dmem.dmem_ack && !m_wmem_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        if (stall) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d   = '0;
            state_d = (ex_m2reg || ex_wmem) ? ACCESS : IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (timed_out) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wreg_q   <= 1'b0;
            m_m2reg_q  <= 1'b0;
            m_wmem_q   <= 1'b0;
            m_aluR_q   <= '0;
            m_inB_q    <= '0;
            m_destR_q  <= '0;
            m_branch_q <= 1'b0;
            m_pc_q     <= '0;
            m_zero_q   <= 1'b0;
            m_type_q   <= '0;
            m_num_q    <= '0;
        end else if (!stall) begin
            m_wreg_q   <= ex_wreg;
            m_m2reg_q  <= ex_m2reg;
            m_wmem_q   <= ex_wmem;
            m_aluR_q   <= ex_aluR;
            m_inB_q    <= ex_inB;
            m_destR_q  <= ex_destR;
            m_branch_q <= ex_branch;
            m_pc_q     <= ex_pc;
            m_zero_q   <= ex_zero;
            m_type_q   <= EXE_ins_type;
            m_num_q    <= EXE_ins_number;
        end
    end

    // Stall cycles inject bubbles; an abandoned access never writes the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_wreg_q  <= 1'b0;
            wb_m2reg_q <= 1'b0;
            wb_aluR_q  <= '0;
            wb_mdata_q <= '0;
            wb_destR_q <= '0;
        end else if (stall) begin
            wb_wreg_q  <= 1'b0;
            wb_m2reg_q <= 1'b0;
        end else begin
            wb_wreg_q  <= m_wreg_q & ~timed_out;
            wb_m2reg_q <= m_m2reg_q;
            wb_aluR_q  <= m_aluR_q;
            wb_destR_q <= m_destR_q;
            if (timed_out)      wb_mdata_q <= '0;
            else if (load_done) wb_mdata_q <= dmem.dmem_rdata;
        end
    end

    assign dmem.dmem_req   = in_access;
    assign dmem.dmem_we    = in_access & m_wmem_q;
    assign dmem.dmem_addr  = m_aluR_q;
    assign dmem.dmem_wdata = m_inB_q;

    assign mem_stall      = stall;
    assign mem_pcsrc      = m_branch_q & m_zero_q;
    assign mem_branch_pc  = m_pc_q;
    assign mem_err        = err_q;
    assign wb_wreg        = wb_wreg_q;
    assign wb_m2reg       = wb_m2reg_q;
    assign wb_aluR        = wb_aluR_q;
    assign wb_mdata       = wb_mdata_q;
    assign wb_destR       = wb_destR_q;
    assign MEM_ins_type   = m_type_q;
    assign MEM_ins_number = m_num_q;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed and random instruction streams against a
// transaction-level model that knows each access's ack latency up front.
module tb_mem_stage;
    localparam int DW      = 32;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ex_wreg, ex_m2reg, ex_wmem, ex_branch, ex_zero;
    logic [DW-1:0] ex_aluR, ex_inB, ex_pc;
    logic [4:0]    ex_destR;
    logic [3:0]    EXE_ins_type, EXE_ins_number;
    logic          mem_stall, mem_pcsrc, mem_err, wb_wreg, wb_m2reg;
    logic [DW-1:0] mem_branch_pc, wb_aluR, wb_mdata;
    logic [4:0]    wb_destR;
    logic [3:0]    MEM_ins_type, MEM_ins_number;

    always #5 clk = ~clk;

    mem_stage_if #(.DW(DW)) dmem_bus ();

    mem_stage #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
        .ex_aluR(ex_aluR), .ex_inB(ex_inB), .ex_destR(ex_destR),
        .ex_branch(ex_branch), .ex_pc(ex_pc), .ex_zero(ex_zero),
        .EXE_ins_type(EXE_ins_type), .EXE_ins_number(EXE_ins_number),
        .dmem(dmem_bus),
        .mem_stall(mem_stall), .mem_pcsrc(mem_pcsrc), .mem_branch_pc(mem_branch_pc),
        .mem_err(mem_err), .wb_wreg(wb_wreg), .wb_m2reg(wb_m2reg),
        .wb_aluR(wb_aluR), .wb_mdata(wb_mdata), .wb_destR(wb_destR),
        .MEM_ins_type(MEM_ins_type), .MEM_ins_number(MEM_ins_number)
    );

    // lat: cycle of the access (1-based) on which memory acks; 0 = never acks.
    typedef struct {
        logic        wreg, m2reg, wmem, branch, zero;
        logic [31:0] aluR, inB, pc, rd;
        logic [4:0]  destR;
        logic [3:0]  typ, num;
        int          lat;
    } instr_t;

    typedef struct {
        logic        wreg, m2reg;
        logic [31:0] aluR, mdata;
        logic [4:0]  destR;
    } wb_t;

    int     n_checks = 0;
    int     n_fail   = 0;
    instr_t cur, nxt;
    instr_t dir_q[$];
    wb_t    wexp;
    int     wait_cnt;
    logic   err_exp;
    bit     rand_en;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic instr_t nop();
        instr_t i;
        i = '{wreg: 0, m2reg: 0, wmem: 0, branch: 0, zero: 0, aluR: 0, inB: 0, pc: 0,
              rd: 0, destR: 0, typ: 0, num: 0, lat: 0};
        return i;
    endfunction

    function automatic instr_t alu(input logic [31:0] r, input logic [4:0] d);
        instr_t i = nop();
        i.wreg = 1; i.aluR = r; i.destR = d;
        i.typ = 4'($urandom); i.num = 4'($urandom);
        return i;
    endfunction

    function automatic instr_t ld(input logic [31:0] a, input int lat, input logic [31:0] rd,
                                  input logic [4:0] d);
        instr_t i = alu(a, d);
        i.m2reg = 1; i.lat = lat; i.rd = rd;
        return i;
    endfunction

    function automatic instr_t st(input logic [31:0] a, input logic [31:0] data, input int lat);
        instr_t i = alu(a, 5'($urandom));
        i.wreg = 0; i.wmem = 1; i.inB = data; i.lat = lat;
        return i;
    endfunction

    function automatic instr_t br(input logic [31:0] pc, input logic z);
        instr_t i = alu($urandom, 5'($urandom));
        i.wreg = 0; i.branch = 1; i.zero = z; i.pc = pc;
        return i;
    endfunction

    function automatic instr_t rnd();
        instr_t i;
        int     lat;
        lat = ($urandom_range(0, 24) == 0) ? 0 :
              ($urandom_range(0, 9) == 0) ? TIMEOUT : int'($urandom_range(1, 5));
        case ($urandom_range(0, 3))
            0:       i = ld($urandom, lat, $urandom, 5'($urandom));
            1:       i = st($urandom, $urandom, lat);
            2:       i = br($urandom, 1'($urandom));
            default: begin i = alu($urandom, 5'($urandom)); i.wreg = 1'($urandom); end
        endcase
        i.inB = $urandom;
        return i;
    endfunction

    function automatic bit is_mem(input instr_t i);
        return i.m2reg || i.wmem;
    endfunction

    // Stall cycles an access costs: one less than its ack cycle, or the full window minus one.
    function automatic int stall_cycles(input instr_t i);
        if (!is_mem(i)) return 0;
        if (i.lat == 0) return TIMEOUT - 1;
        return i.lat - 1;
    endfunction

    task automatic drive_ex(input instr_t i);
        ex_wreg = i.wreg; ex_m2reg = i.m2reg; ex_wmem = i.wmem;
        ex_aluR = i.aluR; ex_inB = i.inB; ex_destR = i.destR;
        ex_branch = i.branch; ex_pc = i.pc; ex_zero = i.zero;
        EXE_ins_type = i.typ; EXE_ins_number = i.num;
    endtask

    task automatic run_cycle();
        logic        exp_stall, ack, timed;
        logic [31:0] rd;
        @(negedge clk);
        exp_stall = is_mem(cur) && (wait_cnt < stall_cycles(cur));
        if (is_mem(cur)) ack = (cur.lat != 0) && (wait_cnt == cur.lat - 1);
        else             ack = ($urandom_range(0, 3) == 0);
        rd = (ack && is_mem(cur)) ? cur.rd : $urandom;
        if (!exp_stall) begin
            if (dir_q.size() > 0) nxt = dir_q.pop_front();
            else if (rand_en)     nxt = rnd();
            else                  nxt = nop();
            drive_ex(nxt);
        end
        dmem_bus.dmem_ack   = ack;
        dmem_bus.dmem_rdata = rd;
        #1;
        chk("dmem_req", dmem_bus.dmem_req, is_mem(cur));
        chk("mem_stall", mem_stall, exp_stall);
        if (is_mem(cur)) begin
            chk("dmem_we", dmem_bus.dmem_we, cur.wmem);
            chk("dmem_addr", dmem_bus.dmem_addr, cur.aluR);
            chk("dmem_wdata", dmem_bus.dmem_wdata, cur.inB);
        end
        chk("mem_pcsrc", mem_pcsrc, cur.branch & cur.zero);
        chk("mem_branch_pc", mem_branch_pc, cur.pc);
        chk("mem_err", mem_err, err_exp);
        chk("MEM_ins_type", MEM_ins_type, cur.typ);
        chk("MEM_ins_number", MEM_ins_number, cur.num);
        @(posedge clk);
        if (exp_stall) begin
            wexp.wreg  = 0;
            wexp.m2reg = 0;
            wait_cnt++;
        end else begin
            timed = is_mem(cur) && (cur.lat == 0);
            if (timed) err_exp = 1;
            wexp.wreg  = cur.wreg && !timed;
            wexp.m2reg = cur.m2reg;
            wexp.aluR  = cur.aluR;
            wexp.destR = cur.destR;
            if (timed)          wexp.mdata = 0;
            else if (cur.m2reg) wexp.mdata = cur.rd;
            cur      = nxt;
            wait_cnt = 0;
        end
        #1;
        chk("wb_wreg", wb_wreg, wexp.wreg);
        chk("wb_m2reg", wb_m2reg, wexp.m2reg);
        chk("wb_aluR", wb_aluR, wexp.aluR);
        chk("wb_destR", wb_destR, wexp.destR);
        chk("wb_mdata", wb_mdata, wexp.mdata);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_req"}, dmem_bus.dmem_req, 0);
        chk({tag, "_stall"}, mem_stall, 0);
        chk({tag, "_wb_wreg"}, wb_wreg, 0);
        chk({tag, "_wb_m2reg"}, wb_m2reg, 0);
        chk({tag, "_wb_aluR"}, wb_aluR, 0);
        chk({tag, "_wb_mdata"}, wb_mdata, 0);
        chk({tag, "_wb_destR"}, wb_destR, 0);
        chk({tag, "_err"}, mem_err, 0);
        chk({tag, "_pcsrc"}, mem_pcsrc, 0);
    endtask

    // Asserted mid-cycle, away from any edge, so only the asynchronous path can clear outputs.
    task automatic do_reset();
        chk("pre_reset_req", dmem_bus.dmem_req, 1);
        rst_n = 0;
        #1;
        reset_checks("async_rst");
        drive_ex(nop());
        dmem_bus.dmem_ack = 0;
        cur      = nop();
        nxt      = nop();
        wexp     = '{wreg: 0, m2reg: 0, aluR: 0, mdata: 0, destR: 0};
        err_exp  = 0;
        wait_cnt = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        drive_ex(nop());
        dmem_bus.dmem_ack   = 0;
        dmem_bus.dmem_rdata = 0;
        cur      = nop();
        nxt      = nop();
        wexp     = '{wreg: 0, m2reg: 0, aluR: 0, mdata: 0, destR: 0};
        err_exp  = 0;
        wait_cnt = 0;
        rand_en  = 0;
        #3;
        reset_checks("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;

        dir_q.push_back(alu(32'h1234, 5'd5));
        dir_q.push_back(ld(32'h40, 3, 32'hCAFEF00D, 5'd7));
        dir_q.push_back(st(32'h80, 32'hA5A5A5A5, 1));
        dir_q.push_back(ld(32'h44, 2, 32'h11112222, 5'd9));
        dir_q.push_back(st(32'h84, 32'h5A5A5A5A, 2));
        dir_q.push_back(br(32'h100, 1'b1));
        dir_q.push_back(br(32'h200, 1'b0));
        dir_q.push_back(alu(32'hDEAD0001, 5'd3));
        dir_q.push_back(ld(32'h48, 0, 32'h0, 5'd11));
        dir_q.push_back(alu(32'h0BADBEEF, 5'd12));
        dir_q.push_back(ld(32'h4C, TIMEOUT, 32'h76543210, 5'd13));
        dir_q.push_back(alu(32'h00000042, 5'd14));
        repeat (70) run_cycle();

        dir_q.push_back(ld(32'h200, 0, 32'h0, 5'd20));
        repeat (5) run_cycle();
        do_reset();

        dir_q.push_back(ld(32'h300, 2, 32'h0F0F1234, 5'd21));
        dir_q.push_back(alu(32'h99, 5'd22));
        repeat (8) run_cycle();

        rand_en = 1;
        repeat (1500) run_cycle();
        rand_en = 0;
        repeat (TIMEOUT + 5) run_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
